// File: rtl/user_wb_pkg.sv
// Shared types and constants for the Wishbone classic burst initiator.
// Holds the FSM state encoding, the latched command record and beat address/data helpers.
package user_wb_pkg;

  localparam int WB_ADR_W   = 32;
  localparam int WB_DAT_W   = 32;
  localparam int WB_SEL_W   = 4;
  localparam int LEN_W      = 8;
  localparam int ADR_STRIDE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat;
    logic [LEN_W-1:0]    len;
  } wb_cmd_t;

  // Address and data for a given beat; both wrap modulo 2^32.
  function automatic logic [WB_ADR_W-1:0] beat_adr(input logic [WB_ADR_W-1:0] base,
                                                   input logic [LEN_W-1:0]    beat);
    return base + WB_ADR_W'(ADR_STRIDE) * WB_ADR_W'(beat);
  endfunction

  function automatic logic [WB_DAT_W-1:0] beat_dat(input logic [WB_DAT_W-1:0] seed,
                                                   input logic [LEN_W-1:0]    beat);
    return seed + WB_DAT_W'(beat);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Per-beat ack timeout: counts cycles spent waiting for ack and flags the last allowed one.
// expired is combinational so the FSM can abort on the same edge the limit is reached.
module wb_timeout_ctr
  import user_wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The edge that would bring the count to TIMEOUT is the abort edge.
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/user_wb_initiator.sv
// Command-driven Wishbone classic master: issues 1..256 incrementing beats with an idle
// cycle between beats, one response pulse per beat, and aborts a beat on ack timeout.
module user_wb_initiator
  import user_wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                rsp_valid_o,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_last_o,
  output logic                rsp_err_o
);

  wb_state_e        state;
  wb_cmd_t          cmd;
  logic [LEN_W-1:0] beat;
  logic             tmo_clear;
  logic             tmo_enable;
  logic             tmo_expired;

  assign tmo_clear  = (state != ST_REQ);
  assign tmo_enable = (state == ST_REQ) && !wbm_ack_i;

  wb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // NOTE: all state and outputs use non-blocking assignments in one clocked block; the
  // reset branch is synchronous, so it lives inside the posedge-only sensitivity list.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state       <= ST_IDLE;
      cmd         <= '0;
      beat        <= '0;
      cmd_ready_o <= 1'b1;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_last_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
    end else begin
      // Response fields are single-cycle pulses and read as zero otherwise.
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_last_o  <= 1'b0;
      rsp_err_o   <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            cmd         <= '{we: cmd_we_i, adr: cmd_adr_i, sel: cmd_sel_i,
                             dat: cmd_dat_i, len: cmd_len_i};
            beat        <= '0;
            state       <= ST_REQ;
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_dat_o   <= cmd_dat_i;
          end
        end

        ST_REQ: begin
          if (wbm_ack_i || tmo_expired) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_sel_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b1;
            // Ack takes priority over a timeout reached on the same edge.
            if (wbm_ack_i) begin
              rsp_dat_o <= cmd.we ? '0 : wbm_dat_i;
              if (beat == cmd.len) begin
                rsp_last_o  <= 1'b1;
                state       <= ST_IDLE;
                cmd_ready_o <= 1'b1;
              end else begin
                beat  <= beat + LEN_W'(1);
                state <= ST_GAP;
              end
            end else begin
              rsp_err_o   <= 1'b1;
              rsp_last_o  <= 1'b1;
              state       <= ST_IDLE;
              cmd_ready_o <= 1'b1;
            end
          end
        end

        ST_GAP: begin
          state     <= ST_REQ;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_we_o  <= cmd.we;
          wbm_adr_o <= beat_adr(cmd.adr, beat);
          wbm_sel_o <= cmd.sel;
          wbm_dat_o <= beat_dat(cmd.dat, beat);
        end

        default: begin
          state       <= ST_IDLE;
          cmd_ready_o <= 1'b1;
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/user_wb_initiator.md
USER_WB_INITIATOR -- requirements
Module: user_wb_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a beat waits for ack before abort.
REQ-002 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid_i  in  1  command request.
REQ-005 cmd_ready_o  out  1  command accepted on cmd_valid_i && cmd_ready_o.
REQ-006 cmd_we_i  in  1  1 = write, 0 = read.
REQ-007 cmd_adr_i  in  32  start byte address, word aligned.
REQ-008 cmd_sel_i  in  4  byte selects for all beats.
REQ-009 cmd_dat_i  in  32  write data seed.
REQ-010 cmd_len_i  in  8  beat count minus one (0 = 1 beat, 255 = 256 beats).
REQ-011 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-012 wbm_adr_o  out  32; wbm_sel_o  out  4; wbm_dat_o  out  32  Wishbone address, selects, write data.
REQ-013 wbm_ack_i  in  1; wbm_dat_i  in  32  Wishbone ack and read data.
REQ-014 rsp_valid_o  out  1  one-cycle response pulse per completed or aborted beat.
REQ-015 rsp_dat_o  out  32  read data (0 for writes and errors).
REQ-016 rsp_last_o  out  1; rsp_err_o  out  1  final beat; timeout abort.

Function
REQ-017 States IDLE, REQ, GAP; cmd_ready_o SHALL be 1 only in IDLE.
REQ-018 On accept at edge N: latch command, beat index 0; wbm_cyc_o = wbm_stb_o = 1 from cycle N+1 (state REQ).
REQ-019 In REQ: wbm_adr_o = cmd_adr + 4*beat (32-bit wrap); wbm_dat_o = cmd_dat + beat (mod 2^32); wbm_we_o, wbm_sel_o held from command.
REQ-020 ack sampled at edge M in REQ: cyc/stb low in cycle M+1; rsp_valid_o = 1 in M+1; rsp_dat_o = wbm_dat_i sampled at M for reads.
REQ-021 Non-final beat: REQ -> GAP -> REQ; next stb high in cycle M+2 (one idle cycle between beats, mandatory).
REQ-022 Final beat (beat == cmd_len): rsp_last_o = 1, state -> IDLE, cmd_ready_o = 1 in cycle M+1.
REQ-023 Timeout counter clears on entry to REQ, increments each REQ cycle without ack; when it reaches TIMEOUT, drop cyc/stb next cycle, pulse rsp_valid_o with rsp_err_o = 1, rsp_last_o = 1, skip remaining beats, return to IDLE.
REQ-024 ack and timeout on same edge: ack wins, no error.
REQ-025 wbm_ack_i outside REQ SHALL be ignored; no response generated.
REQ-026 cmd_valid_i while busy SHALL be ignored (no queueing).
REQ-027 rsp_* SHALL be 0 whenever rsp_valid_o = 0.

Reset
REQ-028 wb_rst_i low at an edge: state IDLE, all outputs 0 except cmd_ready_o = 1 in the next cycle.
REQ-029 Reset mid-transfer SHALL drop cyc/stb next cycle and emit no response for the aborted beat.

Structure
REQ-030 Shared package user_wb_pkg: state enum, ADR_STRIDE = 4, WB data/addr width constants.
REQ-031 Sub-module wb_timeout_ctr (clear, enable, expired) SHALL implement the timeout counter.

Verification
REQ-032 Single write: adr 0x3000_0000, dat 0xA5A5_0000, sel 0xF, len 0, responder acks after 1 cycle -> one stb cycle pair, rsp_valid with last = 1, err = 0, cmd_ready back next cycle.
REQ-033 Burst read len 3 from 0x3000_0010, responder returns adr>>2 -> adr 0x10,0x14,0x18,0x1C with GAP between; rsp_dat 4,5,6,7; last only on 4th.
REQ-034 Burst write len 1, dat 0xFFFF_FFFF -> wbm_dat_o 0xFFFF_FFFF then 0x0000_0000.
REQ-035 No ack, TIMEOUT = 8 -> stb high 8 cycles, single rsp with err = 1, last = 1, dat 0, remaining beats skipped.
REQ-036 Reset asserted during beat 2 of a 4-beat read -> cyc/stb low next cycle, no further rsp_valid, cmd_ready = 1 after release.
REQ-037 Spurious ack in IDLE and cmd_valid while busy -> no response, no second command started.
